// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_t     : arbiter FSM states (IDLE, WAIT_I, WAIT_D)
//   owner_t     : which port issued the outstanding / most recent transaction
//   BE_ALL_ONES : all-ones byte-enable source, sliced to the bus BE width
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Wide enough for any supported DATA_W (up to 1024 bits of data).
   localparam int unsigned MAX_BE_W = 128;
   localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch port (i_*), load/store port (d_*) and
// memory port (m_*) of the arbiter.
//   modport slave  : the arbiter's view (takes core requests, drives memory)
//   modport master : the environment's view (core ports + memory model)
// Handshake: a requester raises *_req_i with a stable payload and holds both
// until *_gnt_o; gnt is only ever given while req is high. Responses arrive as
// a single-cycle *_rvalid_o with *_rdata_o valid in that same cycle.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // fetch port
   logic              i_req_i;
   logic [ADDR_W-1:0] i_addr_i;
   logic              i_gnt_o;
   logic              i_rvalid_o;
   logic [DATA_W-1:0] i_rdata_o;
   // load/store port
   logic              d_req_i;
   logic              d_we_i;
   logic [BE_W-1:0]   d_be_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic              d_gnt_o;
   logic              d_rvalid_o;
   logic [DATA_W-1:0] d_rdata_o;
   // memory port
   logic              m_req_o;
   logic              m_we_o;
   logic [BE_W-1:0]   m_be_o;
   logic [ADDR_W-1:0] m_addr_o;
   logic [DATA_W-1:0] m_wdata_o;
   logic              m_gnt_i;
   logic              m_rvalid_i;
   logic [DATA_W-1:0] m_rdata_i;

   modport slave (
      input  i_req_i, i_addr_i,
      output i_gnt_o, i_rvalid_o, i_rdata_o,
      input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
      input  m_gnt_i, m_rvalid_i, m_rdata_i
   );

   modport master (
      output i_req_i, i_addr_i,
      input  i_gnt_o, i_rvalid_o, i_rdata_o,
      output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
      output m_gnt_i, m_rvalid_i, m_rdata_i
   );

endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles spent waiting for a memory response.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clear        : restart the count (asserted on the grant cycle)
//   run          : a waiting cycle with no response
//   hit_o        : abort pulse; high in the TIMEOUT-th waiting cycle
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic run,
   output logic hit_o
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // The count holds the number of waiting cycles already elapsed, so the
   // cycle whose increment would reach TIMEOUT is the abort cycle.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign hit_o = run && (cnt == LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run && !hit_o) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port (I,
// read-only) and the load/store port (D). One transaction outstanding at a
// time; the response is routed back to the issuing port with zero latency.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : mem_arbiter_if.slave (fetch, load/store and memory ports)
//   stall_o      : stall toward the decoder while a data access is unresolved
//   err_o        : one-cycle pulse when the watchdog aborts a transaction
//   dbg_state    : current FSM state
// Build option: define MEM_ARB_ROUND_ROBIN_EN to let the port that was not
// last granted win when both request; otherwise D always beats I.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   mem_arbiter_if.slave    bus,
   output logic            stall_o,
   output logic            err_o,
   output state_t          dbg_state
);
   localparam int BE_W = DATA_W / 8;

   state_t state, state_nxt;
   owner_t last_owner, last_owner_nxt;

   logic d_wins, i_wins;
   logic wd_clear, wd_run, abort;

   logic              i_gnt, i_rvalid, d_gnt, d_rvalid;
   logic [DATA_W-1:0] i_rdata, d_rdata;
   logic              m_req, m_we;
   logic [BE_W-1:0]   m_be;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              stall, err;

   // Arbitration among the current requesters (only used in IDLE).
   always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_wins = bus.d_req_i && (!bus.i_req_i || (last_owner == OWN_I));
      i_wins = bus.i_req_i && (!bus.d_req_i || (last_owner == OWN_D));
`else
      d_wins = bus.d_req_i;
      i_wins = bus.i_req_i && !bus.d_req_i;
`endif
   end

   // A response arriving in the timeout cycle wins, so run excludes it.
   assign wd_run = (state != IDLE) && !bus.m_rvalid_i;

   mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clear (wd_clear),
      .run   (wd_run),
      .hit_o (abort)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         last_owner <= OWN_I;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // Outputs are forced to zero while reset is held so a reset in the middle
   // of a transaction silences every port immediately.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      wd_clear       = 1'b0;
      i_gnt          = 1'b0;
      i_rvalid       = 1'b0;
      i_rdata        = '0;
      d_gnt          = 1'b0;
      d_rvalid       = 1'b0;
      d_rdata        = '0;
      m_req          = 1'b0;
      m_we           = 1'b0;
      m_be           = '0;
      m_addr         = '0;
      m_wdata        = '0;
      stall          = 1'b0;
      err            = 1'b0;
      if (rst_i) begin
         unique case (state)
            IDLE: begin
               if (d_wins) begin
                  m_req   = 1'b1;
                  m_we    = bus.d_we_i;
                  m_be    = bus.d_be_i;
                  m_addr  = bus.d_addr_i;
                  m_wdata = bus.d_wdata_i;
                  d_gnt   = bus.m_gnt_i;
                  if (bus.m_gnt_i) begin
                     state_nxt      = WAIT_D;
                     last_owner_nxt = OWN_D;
                     wd_clear       = 1'b1;
                  end
               end else if (i_wins) begin
                  m_req  = 1'b1;
                  m_be   = BE_ALL_ONES[BE_W-1:0];
                  m_addr = bus.i_addr_i;
                  i_gnt  = bus.m_gnt_i;
                  if (bus.m_gnt_i) begin
                     state_nxt      = WAIT_I;
                     last_owner_nxt = OWN_I;
                     wd_clear       = 1'b1;
                  end
               end
               stall = bus.d_req_i && !d_gnt;
            end
            WAIT_I: begin
               if (bus.m_rvalid_i) begin
                  i_rvalid  = 1'b1;
                  i_rdata   = bus.m_rdata_i;
                  state_nxt = IDLE;
               end else if (abort) begin
                  i_rvalid  = 1'b1;
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
               // A fetch wait only stalls when a data access is queued behind it.
               stall = bus.d_req_i;
            end
            WAIT_D: begin
               if (bus.m_rvalid_i) begin
                  d_rvalid  = 1'b1;
                  d_rdata   = bus.m_rdata_i;
                  state_nxt = IDLE;
               end else if (abort) begin
                  d_rvalid  = 1'b1;
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
               stall = !bus.m_rvalid_i && !abort;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.i_gnt_o    = i_gnt;
   assign bus.i_rvalid_o = i_rvalid;
   assign bus.i_rdata_o  = i_rdata;
   assign bus.d_gnt_o    = d_gnt;
   assign bus.d_rvalid_o = d_rvalid;
   assign bus.d_rdata_o  = d_rdata;
   assign bus.m_req_o    = m_req;
   assign bus.m_we_o     = m_we;
   assign bus.m_be_o     = m_be;
   assign bus.m_addr_o   = m_addr;
   assign bus.m_wdata_o  = m_wdata;
   assign stall_o        = stall;
   assign err_o          = err;
   assign dbg_state      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (TIMEOUT = 4). Responses
// are predicted into exp_q when a transaction is granted; a monitor on the
// falling edge pops and compares whenever either port presents rvalid.
// Entry layout: {port (1 = D), err, data}.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;
   localparam int W       = DATA_W + 2;

   logic   clk = 1'b0;
   logic   rst_i;
   logic   stall, err;
   state_t dbg_state;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .bus       (bus),
      .stall_o   (stall),
      .err_o     (err),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_got, mon_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void expect_rsp(input logic is_d, input logic e, input logic [DATA_W-1:0] d);
      exp_q.push_back({is_d, e, d});
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (bus.i_rvalid_o || bus.d_rvalid_o) begin
         check("rvalid_one_port", 64'(bus.i_rvalid_o & bus.d_rvalid_o), 64'd0);
         mon_got = {bus.d_rvalid_o, err, bus.d_rvalid_o ? bus.d_rdata_o : bus.i_rdata_o};
         check("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("response", 64'(mon_got), 64'(mon_exp));
         end
      end else begin
         check("err_without_rvalid", 64'(err), 64'd0);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_req_i    = 1'b0;
      bus.i_addr_i   = '0;
      bus.d_req_i    = 1'b0;
      bus.d_we_i     = 1'b0;
      bus.d_be_i     = '0;
      bus.d_addr_i   = '0;
      bus.d_wdata_i  = '0;
      bus.m_gnt_i    = 1'b0;
      bus.m_rvalid_i = 1'b0;
      bus.m_rdata_i  = '0;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_i_gnt"},    64'(bus.i_gnt_o),    64'd0);
      check({name, "_d_gnt"},    64'(bus.d_gnt_o),    64'd0);
      check({name, "_i_rvalid"}, 64'(bus.i_rvalid_o), 64'd0);
      check({name, "_d_rvalid"}, 64'(bus.d_rvalid_o), 64'd0);
      check({name, "_m_req"},    64'(bus.m_req_o),    64'd0);
   endtask

   logic exp_d [4];

   initial begin
      // ---------------- reset ----------------
      idle_inputs();
      rst_i          = 1'b0;
      bus.i_req_i    = 1'b1;
      bus.d_req_i    = 1'b1;
      bus.d_addr_i   = 32'h2000;
      bus.m_gnt_i    = 1'b1;
      bus.m_rvalid_i = 1'b1;
      bus.m_rdata_i  = 32'h1234_5678;
      #3;
      check_quiet("rst");
      check("rst_stall",  64'(stall),     64'd0);
      check("rst_err",    64'(err),       64'd0);
      check("rst_m_addr", 64'(bus.m_addr_o), 64'd0);
      check("rst_d_rdata", 64'(bus.d_rdata_o), 64'd0);
      check("rst_state",  64'(dbg_state), 64'(IDLE));
      repeat (2) @(posedge clk);
      #1;
      idle_inputs();
      rst_i = 1'b1;

      // ---------------- single fetch ----------------
      next_cycle();
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h100; bus.m_gnt_i = 1'b1;
      expect_rsp(1'b0, 1'b0, 32'h0050_0093);
      sample();
      check("f_i_gnt",  64'(bus.i_gnt_o),  64'd1);
      check("f_d_gnt",  64'(bus.d_gnt_o),  64'd0);
      check("f_m_req",  64'(bus.m_req_o),  64'd1);
      check("f_m_addr", 64'(bus.m_addr_o), 64'h100);
      check("f_m_we",   64'(bus.m_we_o),   64'd0);
      check("f_m_be",   64'(bus.m_be_o),   64'hF);
      check("f_stall",  64'(stall),        64'd0);
      next_cycle();
      bus.i_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      sample();
      check("f_wait_state", 64'(dbg_state), 64'(WAIT_I));
      check("f_wait_m_req", 64'(bus.m_req_o), 64'd0);
      check("f_wait_stall", 64'(stall), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0050_0093;
      sample();
      check("f_rsp_stall", 64'(stall), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b0;
      sample();
      check("f_back_idle", 64'(dbg_state), 64'(IDLE));

      // stale response in IDLE is ignored
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0000_0BAD;
      sample();
      check_quiet("stale");
      next_cycle();
      bus.m_rvalid_i = 1'b0;

      // ---------------- simultaneous requests ----------------
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h104;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h2000;
      bus.m_gnt_i = 1'b1;
      expect_rsp(1'b1, 1'b0, 32'h1111_2222);
      sample();
      check("s_d_gnt",  64'(bus.d_gnt_o),  64'd1);
      check("s_i_gnt",  64'(bus.i_gnt_o),  64'd0);
      check("s_m_addr", 64'(bus.m_addr_o), 64'h2000);
      check("s_stall0", 64'(stall),        64'd0);
      next_cycle();
      bus.d_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      sample();
      check("s_wait_stall", 64'(stall), 64'd1);
      check("s_wait_i_gnt", 64'(bus.i_gnt_o), 64'd0);
      check("s_wait_m_req", 64'(bus.m_req_o), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h1111_2222;
      bus.m_gnt_i = 1'b1;
      sample();
      check("s_rsp_stall", 64'(stall), 64'd0);
      check("s_rsp_i_gnt", 64'(bus.i_gnt_o), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b0;
      expect_rsp(1'b0, 1'b0, 32'hAAAA_5555);
      sample();
      check("s_i_gnt_after", 64'(bus.i_gnt_o),  64'd1);
      check("s_i_m_addr",    64'(bus.m_addr_o), 64'h104);
      // store queued behind the fetch: stall while the fetch is outstanding
      next_cycle();
      bus.i_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
      bus.d_addr_i = 32'h2004; bus.d_wdata_i = 32'hDEAD_BEEF;
      sample();
      check("wi_stall", 64'(stall), 64'd1);
      check("wi_d_gnt", 64'(bus.d_gnt_o), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hAAAA_5555;
      sample();
      check("wi_rsp_stall", 64'(stall), 64'd1);

      // ---------------- store ----------------
      next_cycle();
      bus.m_rvalid_i = 1'b0; bus.m_gnt_i = 1'b1;
      expect_rsp(1'b1, 1'b0, 32'h1234_5678);
      sample();
      check("st_d_gnt",   64'(bus.d_gnt_o),   64'd1);
      check("st_m_we",    64'(bus.m_we_o),    64'd1);
      check("st_m_be",    64'(bus.m_be_o),    64'h3);
      check("st_m_addr",  64'(bus.m_addr_o),  64'h2004);
      check("st_m_wdata", 64'(bus.m_wdata_o), 64'hDEAD_BEEF);
      next_cycle();
      bus.d_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      sample();
      check("st_wait_stall", 64'(stall), 64'd1);
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h1234_5678;
      sample();
      next_cycle();
      idle_inputs();

      // ---------------- watchdog abort on D ----------------
      bus.d_req_i = 1'b1; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h3000; bus.m_gnt_i = 1'b1;
      expect_rsp(1'b1, 1'b1, 32'h0);
      sample();
      check("wd_d_gnt", 64'(bus.d_gnt_o), 64'd1);
      for (int c = 1; c < TIMEOUT; c++) begin
         next_cycle();
         bus.d_req_i = 1'b0; bus.m_gnt_i = 1'b0;
         sample();
         check("wd_wait_stall", 64'(stall), 64'd1);
         check("wd_wait_err",   64'(err),   64'd0);
      end
      next_cycle();
      sample();
      check("wd_abort_err",   64'(err),   64'd1);
      check("wd_abort_stall", 64'(stall), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0000_0BAD;
      sample();
      check("wd_idle_state", 64'(dbg_state), 64'(IDLE));
      check_quiet("wd_late");
      next_cycle();
      bus.m_rvalid_i = 1'b0;

      // ---------------- response in the timeout cycle wins ----------------
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h10C; bus.m_gnt_i = 1'b1;
      expect_rsp(1'b0, 1'b0, 32'hCAFE_F00D);
      sample();
      check("pr_i_gnt", 64'(bus.i_gnt_o), 64'd1);
      for (int c = 1; c < TIMEOUT; c++) begin
         next_cycle();
         bus.i_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      end
      next_cycle();
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hCAFE_F00D;
      sample();
      check("pr_err", 64'(err), 64'd0);
      next_cycle();
      bus.m_rvalid_i = 1'b0;

      // ---------------- reset mid-transaction ----------------
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h4000;
      bus.m_gnt_i = 1'b1;
      sample();
      check("rm_d_gnt", 64'(bus.d_gnt_o), 64'd1);
      next_cycle();
      bus.d_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      sample();
      check("rm_state", 64'(dbg_state), 64'(WAIT_D));
      check("rm_stall", 64'(stall), 64'd1);
      #2;
      rst_i = 1'b0;
      bus.d_req_i = 1'b1; bus.m_gnt_i = 1'b1;
      #1;
      check_quiet("rm_async");
      check("rm_async_stall", 64'(stall), 64'd0);
      check("rm_async_state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      bus.d_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0000_5555;
      sample();
      check_quiet("rm_held");
      next_cycle();
      rst_i = 1'b1;
      sample();
      check_quiet("rm_late");
      check("rm_late_state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      bus.m_rvalid_i = 1'b0;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h108; bus.m_gnt_i = 1'b1;
      expect_rsp(1'b0, 1'b0, 32'h0BAD_F00D);
      sample();
      check("rm_fetch_gnt", 64'(bus.i_gnt_o), 64'd1);
      next_cycle();
      bus.i_req_i = 1'b0; bus.m_gnt_i = 1'b0;
      bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0BAD_F00D;
      sample();
      next_cycle();
      idle_inputs();

      // ---------------- both ports requesting continuously ----------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int k = 0; k < 4; k++) begin
         if (k != 0) next_cycle();
         bus.i_req_i = 1'b1; bus.i_addr_i = 32'h200 + 32'(k * 4);
         bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF;
         bus.d_addr_i = 32'h5000 + 32'(k * 4);
         bus.m_gnt_i = 1'b1; bus.m_rvalid_i = 1'b0;
         expect_rsp(exp_d[k], 1'b0, 32'h7000_0000 + 32'(k));
         sample();
         check("arb_d_gnt", 64'(bus.d_gnt_o), 64'(exp_d[k]));
         check("arb_i_gnt", 64'(bus.i_gnt_o), 64'(!exp_d[k]));
         next_cycle();
         bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b1;
         bus.m_rdata_i = 32'h7000_0000 + 32'(k);
         sample();
         check("arb_rsp_stall", 64'(stall), 64'(!exp_d[k]));
      end
      next_cycle();
      idle_inputs();
      next_cycle();
      next_cycle();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (I, read-only) and the load/store port (D, read/write) of the pipeline core.
- Allows one outstanding transaction at a time and routes the response back to the port that issued it.
- Raises stall_o toward the decoder while a data access is unresolved.
- Watchdog aborts transactions the memory never answers.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; BE width = DATA_W/8.
- TIMEOUT, 255, cycles spent waiting for m_rvalid_i before abort (1..65535); counter width = $clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- i_req_i  in  1  fetch request
- i_addr_i  in  ADDR_W  fetch address
- i_gnt_o  out  1  fetch request accepted
- i_rvalid_o  out  1  fetch data valid
- i_rdata_o  out  DATA_W  fetch data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store
- d_be_i  in  DATA_W/8  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data valid / store acknowledge
- d_rdata_o  out  DATA_W  load data
- m_req_o  out  1  memory request
- m_we_o  out  1  memory write
- m_be_o  out  DATA_W/8  memory byte enables
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_gnt_i  in  1  memory accepts request
- m_rvalid_i  in  1  memory response valid (reads and writes)
- m_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  pipeline stall toward decoder
- err_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- FSM states are IDLE, WAIT_I and WAIT_D.
- Reset: state IDLE, watchdog counter 0, last_owner = I, err_o = 0. All *_gnt_o, *_rvalid_o and m_req_o read 0. Data outputs read 0.
- Request rule: requesters hold req and their payload stable until gnt. gnt is never asserted without req.
- IDLE arbitration (combinational): with d_req_i set, D wins; otherwise, with i_req_i set, I wins. m_req_o = winner present. m_we/be/addr/wdata are driven from the winner. For an I winner, m_we_o = 0 and m_be_o = all ones.
- IDLE grant: winner's gnt_o = m_gnt_i in the same cycle. The loser's gnt_o = 0. On m_gnt_i the FSM goes to WAIT_<winner> and last_owner is updated.
- WAIT_x: m_req_o = 0 and no new grant is given.
  - On m_rvalid_i, x_rvalid_o = 1 and x_rdata_o = m_rdata_i in the same cycle (zero-latency pass-through). Next state is IDLE.
  - Earliest next grant is the cycle after the response, so back-to-back transactions take 2 cycles minimum each.
- Non-owner rvalid_o is always 0. m_rvalid_i in IDLE is ignored (stale response).
- Watchdog counter: cleared on entry to WAIT_x and increments each WAIT cycle without m_rvalid_i.
- Watchdog abort: when the count reaches TIMEOUT, x_rvalid_o = 1, x_rdata_o = 0 and err_o = 1 for that cycle, then the FSM goes to IDLE.
- m_rvalid_i in the abort cycle takes precedence: normal completion, no err_o.
- stall_o = (d_req_i & ~d_gnt_o in IDLE) | (state == WAIT_D & ~m_rvalid_i & ~abort) | (state == WAIT_I & d_req_i). Fetch waits never stall by themselves.
- Reset mid-transaction: the FSM returns to IDLE immediately and the pending transaction is dropped with no rvalid to the requester. A late m_rvalid_i is ignored.
- Address and data pass through unmodified; no alignment checks.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, the port that is not last_owner wins. A single requester always wins.
- Undefined: fixed D-over-I priority; the last_owner register is still present but does not affect arbitration.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, WAIT_I, WAIT_D}
  - owner_t enum {OWN_I, OWN_D}
  - localparam BE_ALL_ONES
- Sub-module mem_arb_watchdog: counter plus compare, with inputs clk_i, rst_i, clear, run, hit_o, producing the abort pulse.
- Arbitration, muxing and the FSM stay in the top module.

Test Plan:
- Single fetch: i_req=1, addr 0x100; m_gnt same cycle, m_rvalid 2 cycles later with 0x00500093 -> i_gnt=1 at cycle 0, i_rvalid=1 with i_rdata=0x00500093 at cycle 2, stall_o=0 throughout.
- Simultaneous requests, fixed priority: i_req and d_req (load 0x2000) in the same cycle -> D granted, I granted the cycle after the D response, stall_o=1 until d_rvalid.
- Store: d_we=1, be=4'b0011, addr 0x2004, wdata 0xDEADBEEF -> m_we=1, m_be=0011, m_wdata=0xDEADBEEF, and d_rvalid on the memory ack.
- Watchdog: TIMEOUT=4, grant D, withhold m_rvalid -> d_rvalid=1, d_rdata=0 and err_o=1 at cycle 4 after grant, FSM back in IDLE. A late m_rvalid next cycle produces no rvalid on either port.
- Reset mid-transaction: assert rst_i low during WAIT_D -> all outputs 0 asynchronously. After release, a fresh fetch completes normally.
- With MEM_ARB_ROUND_ROBIN_EN: both ports requesting continuously -> grants alternate D, I, D, I.
